// File: rtl/record_fifo.sv
// Single-clock record FIFO behind the write arbiter. Read data is registered,
// occupancy is an explicit counter, and overflow/underflow are sticky.
module record_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_we,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic              i_clear,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rvalid,
  output logic [AW:0]       o_records,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              full_q, empty_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ovf_q, udf_q;
  logic              rd_ok, wr_ok;

  // A pending clear suppresses both ports so they neither move state nor set flags.
  always_comb begin
    rd_ok    = i_re && !empty_q && !i_clear;
    wr_ok    = i_we && (!full_q || rd_ok) && !i_clear;
    wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else if (i_clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == FULL_CNT);
      empty_q  <= (count_d == '0);
      rvalid_q <= rd_ok;
      if (rd_ok) begin
        rdata_q <= mem_q[rd_ptr_q];
      end
      if (i_we && !wr_ok) begin
        ovf_q <= 1'b1;
      end
      // Empty plus read is rejected even when a write lands the same cycle.
      if (i_re && empty_q) begin
        udf_q <= 1'b1;
      end
    end
  end

  assign o_rdata     = rdata_q;
  assign o_rvalid    = rvalid_q;
  assign o_records   = count_q;
  assign o_full      = full_q;
  assign o_empty     = empty_q;
  assign o_overflow  = ovf_q;
  assign o_underflow = udf_q;

endmodule

// File: tb/tb_record_fifo.sv
// Self-checking bench for record_fifo: directed table, corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_record_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int AW     = 3;

  logic              i_clk = 1'b0;
  logic              i_reset_n;
  logic              i_we;
  logic [DATA_W-1:0] i_wdata;
  logic              i_re;
  logic              i_clear;
  logic [DATA_W-1:0] o_rdata;
  logic              o_rvalid;
  logic [AW:0]       o_records;
  logic              o_full;
  logic              o_empty;
  logic              o_overflow;
  logic              o_underflow;

  record_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_we        (i_we),
    .i_wdata     (i_wdata),
    .i_re        (i_re),
    .i_clear     (i_clear),
    .o_rdata     (o_rdata),
    .o_rvalid    (o_rvalid),
    .o_records   (o_records),
    .o_full      (o_full),
    .o_empty     (o_empty),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mq[$];
  logic              m_rvalid;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ovf;
  logic              m_udf;

  typedef struct {
    logic        we;
    logic [7:0]  wd;
    logic        re;
    logic        clr;
    int          rec;
    logic        rv;
    logic [7:0]  rd;
    logic        ovf;
    logic        udf;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_rvalid = 1'b0;
    m_rdata  = '0;
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
  endtask

  task automatic model_step(input logic we, input logic [7:0] wd, input logic re, input logic clr);
    bit was_empty;
    bit rd;
    bit wr;
    if (clr) begin
      mq.delete();
      m_ovf    = 1'b0;
      m_udf    = 1'b0;
      m_rvalid = 1'b0;
    end else begin
      was_empty = (mq.size() == 0);
      rd = re && !was_empty;
      wr = we && ((mq.size() < DEPTH) || rd);
      if (rd) m_rdata = mq.pop_front();
      m_rvalid = rd;
      if (wr) mq.push_back(wd);
      if (we && !wr) m_ovf = 1'b1;
      if (re && was_empty) m_udf = 1'b1;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".records"}, 32'(o_records), 32'(mq.size()));
    chk({tag, ".full"},    32'(o_full),    32'(mq.size() == DEPTH));
    chk({tag, ".empty"},   32'(o_empty),   32'(mq.size() == 0));
    chk({tag, ".rvalid"},  32'(o_rvalid),  32'(m_rvalid));
    chk({tag, ".rdata"},   32'(o_rdata),   32'(m_rdata));
    chk({tag, ".ovf"},     32'(o_overflow),  32'(m_ovf));
    chk({tag, ".udf"},     32'(o_underflow), 32'(m_udf));
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step(input string tag, input logic we, input logic [7:0] wd,
                      input logic re, input logic clr);
    i_we    = we;
    i_wdata = wd;
    i_re    = re;
    i_clear = clr;
    @(posedge i_clk);
    model_step(we, wd, re, clr);
    #1;
    i_we    = 1'b0;
    i_re    = 1'b0;
    i_clear = 1'b0;
    check_model(tag);
  endtask

  initial begin
    i_reset_n = 1'b0;
    i_we      = 1'b0;
    i_wdata   = '0;
    i_re      = 1'b0;
    i_clear   = 1'b0;
    model_reset();

    vt[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 1, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 2, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[2] = '{1'b1, 8'h33, 1'b0, 1'b0, 3, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b1, 8'h11, 1'b0, 1'b0};
    vt[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 8'h22, 1'b0, 1'b0};
    vt[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 8'h33, 1'b0, 1'b0};
    vt[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h33, 1'b0, 1'b0};
    vt[7] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1, 1'b0, 8'h33, 1'b0, 1'b1};
    vt[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 8'h5A, 1'b0, 1'b1};
    vt[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h5A, 1'b0, 1'b0};

    repeat (3) @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step("idle", 1'b0, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      step($sformatf("vec%0d", i), vt[i].we, vt[i].wd, vt[i].re, vt[i].clr);
      chk($sformatf("tbl%0d.records", i), 32'(o_records), 32'(vt[i].rec));
      chk($sformatf("tbl%0d.rvalid", i),  32'(o_rvalid),  32'(vt[i].rv));
      chk($sformatf("tbl%0d.rdata", i),   32'(o_rdata),   32'(vt[i].rd));
      chk($sformatf("tbl%0d.ovf", i),     32'(o_overflow),  32'(vt[i].ovf));
      chk($sformatf("tbl%0d.udf", i),     32'(o_underflow), 32'(vt[i].udf));
      chk($sformatf("tbl%0d.empty", i),   32'(o_empty),   32'(vt[i].rec == 0));
    end

    // Fill, overflow, drain in order.
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    step("ovf_wr", 1'b1, 8'hAA, 1'b0, 1'b0);
    chk("ovf.full", 32'(o_full), 32'd1);
    chk("ovf.records", 32'(o_records), 32'd8);
    chk("ovf.flag", 32'(o_overflow), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
      chk($sformatf("drain%0d.rdata", i), 32'(o_rdata), 32'(i));
    end
    step("drained", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("drained.empty", 32'(o_empty), 32'd1);

    // Full with simultaneous write and read, then wrap-around.
    step("clr1", 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step("fill2", 1'b1, 8'(i), 1'b0, 1'b0);
    step("full_wr_rd", 1'b1, 8'hBB, 1'b1, 1'b0);
    chk("fullwr.rdata", 32'(o_rdata), 32'h00);
    chk("fullwr.records", 32'(o_records), 32'd8);
    chk("fullwr.ovf", 32'(o_overflow), 32'd0);
    for (int i = 1; i <= DEPTH; i++) step("wrap", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("wrap.rdata", 32'(o_rdata), 32'hBB);

    // Clear wins over a concurrent write.
    for (int i = 0; i < 5; i++) step("fill5", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    step("clr_we", 1'b1, 8'hCC, 1'b0, 1'b1);
    chk("clr.records", 32'(o_records), 32'd0);
    chk("clr.empty", 32'(o_empty), 32'd1);
    chk("clr.flags", 32'({o_overflow, o_underflow}), 32'd0);

    // Asynchronous reset mid-burst, away from any rising edge.
    step("burst", 1'b1, 8'h71, 1'b0, 1'b0);
    step("burst", 1'b1, 8'h72, 1'b0, 1'b0);
    step("burst", 1'b1, 8'h73, 1'b1, 1'b0);
    step("burst", 1'b1, 8'h74, 1'b1, 1'b0);
    #2;
    i_reset_n = 1'b0;
    #1;
    chk("arst.records", 32'(o_records), 32'd0);
    chk("arst.empty", 32'(o_empty), 32'd1);
    chk("arst.full", 32'(o_full), 32'd0);
    chk("arst.rvalid", 32'(o_rvalid), 32'd0);
    chk("arst.rdata", 32'(o_rdata), 32'd0);
    model_reset();
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    step("post_rst", 1'b0, 8'h00, 1'b0, 1'b0);

    // Randomized traffic with alternating fill-heavy and drain-heavy phases.
    for (int i = 0; i < 600; i++) begin
      int wp;
      int rp;
      wp = ((i / 40) % 2 == 0) ? 75 : 30;
      rp = ((i / 40) % 2 == 0) ? 30 : 75;
      step("rand",
           $urandom_range(0, 99) < wp,
           8'($urandom),
           $urandom_range(0, 99) < rp,
           $urandom_range(0, 99) < 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
